// File: rtl/ft6206_defines.sv
// Shared types and constants for the FT6206 touch polling datapath.
// Contents:
//   i2c_cmd_t       command codes understood by the byte-level I2C master
//   touch_t         published touch sample {valid, x, y}
//   poller_state_t  states of the poll sequencer
//   FT6206 register / event constants and the default bus address
package ft6206_defines;

   typedef enum logic [2:0] {
      CMD_START_W   = 3'd0,
      CMD_START_R   = 3'd1,
      CMD_WRITE     = 3'd2,
      CMD_READ_ACK  = 3'd3,
      CMD_READ_NACK = 3'd4,
      CMD_STOP      = 3'd5
   } i2c_cmd_t;

   typedef struct packed {
      logic        valid;
      logic [11:0] x;
      logic [11:0] y;
   } touch_t;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START_W = 3'd1,
      S_WR_REG  = 3'd2,
      S_START_R = 3'd3,
      S_READ    = 3'd4,
      S_STOP    = 3'd5,
      S_UPDATE  = 3'd6,
      S_ABORT   = 3'd7
   } poller_state_t;

   // First register of the burst read; the chip auto-increments through
   // P1_XH, P1_XL, P1_YH, P1_YL.
   localparam logic [7:0] FT_REG_TD_STATUS = 8'h02;
   localparam logic [1:0] EVT_LIFT         = 2'b01;
   localparam logic [6:0] FT_DEFAULT_ADDR  = 7'h38;
   localparam logic [2:0] LAST_BYTE_IDX    = 3'd4;

   function automatic logic [11:0] clamp12(input logic [11:0] v, input logic [11:0] lim);
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/ft6206_poller_poll_timer.sv
// Free-running poll period timer.
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   clear    poll has been taken; drop the pending request
//   pending  a terminal count occurred and has not yet been serviced
// The counter never stops, so a late-serviced poll does not shift the phase
// of later polls. Several ticks that land while a poll is outstanding collapse
// into one pending request.
module poll_timer #(
   parameter int CYCLES = 120_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic pending
);

   localparam int            CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

   logic [CW-1:0] count_q, count_d;
   logic          pending_q, pending_d;
   logic          tick;

   // A tick coinciding with clear is a fresh period, so it wins and
   // re-arms the request.
   always_comb begin
      tick      = (count_q == LAST);
      count_d   = tick ? '0 : count_q + 1'b1;
      pending_d = pending_q;
      if (clear) pending_d = 1'b0;
      if (tick)  pending_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q   <= '0;
         pending_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;

endmodule

// File: rtl/ft6206_poller.sv
// FT6206 touch controller poller.
// Every poll period it reads TD_STATUS..P1_YL over the shared byte-level I2C
// master, converts the bytes into a clamped touch_t sample and publishes it.
// Ports:
//   clk, rst                    system clock, asynchronous active-high reset
//   ena                         allow new polls to start
//   cmd_valid/cmd_ready         command handshake to the I2C master
//   cmd, cmd_addr, cmd_data     command code, slave address, write byte
//   rx_valid, rx_data           read byte strobe and value from the master
//   nack                        slave refused the address or a written byte
//   touch                       registered touch sample
//   err_count                   saturating count of aborted transactions
//   busy                        a transaction is in progress
module ft6206_poller
   import ft6206_defines::*;
#(
   parameter int         CLK_HZ         = 12_000_000,
   parameter int         POLL_HZ        = 100,
   parameter logic [6:0] I2C_ADDR       = FT_DEFAULT_ADDR,
   parameter int         DISPLAY_WIDTH  = 240,
   parameter int         DISPLAY_HEIGHT = 320
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output i2c_cmd_t   cmd,
   output logic [6:0] cmd_addr,
   output logic [7:0] cmd_data,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       nack,
   output touch_t     touch,
   output logic [7:0] err_count,
   output logic       busy
);

   localparam int          POLL_CYCLES = CLK_HZ / POLL_HZ;
   localparam logic [11:0] X_MAX       = 12'(DISPLAY_WIDTH - 1);
   localparam logic [11:0] Y_MAX       = 12'(DISPLAY_HEIGHT - 1);

   poller_state_t   state_q, state_d;
   logic            cmd_valid_q, cmd_valid_d;
   logic            wait_rx_q, wait_rx_d;
   logic [2:0]      idx_q, idx_d;
   logic [4:0][7:0] bytes_q, bytes_d;
   touch_t          touch_q, touch_d;
   logic [7:0]      err_count_q, err_count_d;

   logic            poll_pending;
   logic            poll_clear;
   logic            xfer;
   logic            issue;
   logic            abort_now;
   logic [3:0]      n_points;
   logic [1:0]      evt;
   logic [11:0]     raw_x;
   logic [11:0]     raw_y;
   logic            sample_ok;

   poll_timer #(
      .CYCLES (POLL_CYCLES)
   ) u_poll_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (poll_clear),
      .pending (poll_pending)
   );

   // Reserved bits of the status/coordinate bytes carry no information.
   logic unused_bits;
   assign unused_bits = &{1'b0, bytes_q[0][7:4], bytes_q[1][5:4], bytes_q[3][7:4]};

   // Command code follows the state; it cannot change while cmd_valid is
   // waiting for cmd_ready because the state only moves on a transfer, an
   // rx byte or an abort (which also drops cmd_valid).
   always_comb begin
      cmd = CMD_STOP;
      case (state_q)
         S_START_W: cmd = CMD_START_W;
         S_WR_REG:  cmd = CMD_WRITE;
         S_START_R: cmd = CMD_START_R;
         S_READ:    cmd = (idx_q == LAST_BYTE_IDX) ? CMD_READ_NACK : CMD_READ_ACK;
         default:   cmd = CMD_STOP;
      endcase
   end

   // Sequencer. Each command state raises cmd_valid one cycle after entry,
   // holds it until the master takes the command, then advances. Reads also
   // park in wait_rx until the byte arrives. A nack after the address phase
   // pre-empts everything, including a same-cycle rx byte.
   always_comb begin
      state_d     = state_q;
      cmd_valid_d = cmd_valid_q;
      wait_rx_d   = wait_rx_q;
      idx_d       = idx_q;
      bytes_d     = bytes_q;
      touch_d     = touch_q;
      err_count_d = err_count_q;
      poll_clear  = 1'b0;

      xfer      = cmd_valid_q && cmd_ready;
      issue     = !cmd_valid_q && !wait_rx_q;
      abort_now = nack && (state_q inside {S_WR_REG, S_START_R, S_READ, S_STOP});

      n_points  = bytes_q[0][3:0];
      evt       = bytes_q[1][7:6];
      raw_x     = {bytes_q[1][3:0], bytes_q[2]};
      raw_y     = {bytes_q[3][3:0], bytes_q[4]};
      sample_ok = ((n_points == 4'd1) || (n_points == 4'd2)) && (evt != EVT_LIFT);

      if (abort_now) begin
         state_d     = S_ABORT;
         cmd_valid_d = 1'b0;
         wait_rx_d   = 1'b0;
         idx_d       = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (poll_pending && ena) begin
                  poll_clear = 1'b1;
                  state_d    = S_START_W;
               end
            end
            S_START_W: begin
               if (xfer) begin
                  cmd_valid_d = 1'b0;
                  state_d     = S_WR_REG;
               end else if (issue) begin
                  cmd_valid_d = 1'b1;
               end
            end
            S_WR_REG: begin
               if (xfer) begin
                  cmd_valid_d = 1'b0;
                  state_d     = S_START_R;
               end else if (issue) begin
                  cmd_valid_d = 1'b1;
               end
            end
            S_START_R: begin
               if (xfer) begin
                  cmd_valid_d = 1'b0;
                  idx_d       = '0;
                  state_d     = S_READ;
               end else if (issue) begin
                  cmd_valid_d = 1'b1;
               end
            end
            S_READ: begin
               if (xfer) begin
                  cmd_valid_d = 1'b0;
                  wait_rx_d   = 1'b1;
               end else if (wait_rx_q && rx_valid) begin
                  bytes_d[idx_q] = rx_data;
                  wait_rx_d      = 1'b0;
                  if (idx_q == LAST_BYTE_IDX) begin
                     idx_d   = '0;
                     state_d = S_STOP;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end else if (issue) begin
                  cmd_valid_d = 1'b1;
               end
            end
            S_STOP: begin
               if (xfer) begin
                  cmd_valid_d = 1'b0;
                  state_d     = S_UPDATE;
               end else if (issue) begin
                  cmd_valid_d = 1'b1;
               end
            end
            S_UPDATE: begin
               // Invalid or lift-up samples keep the last good coordinates
               // so the drawing logic does not jump to a stale position.
               touch_d.valid = sample_ok;
               if (sample_ok) begin
                  touch_d.x = clamp12(raw_x, X_MAX);
                  touch_d.y = clamp12(raw_y, Y_MAX);
               end
               state_d = S_IDLE;
            end
            S_ABORT: begin
               if (xfer) begin
                  cmd_valid_d = 1'b0;
                  if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                  state_d = S_IDLE;
               end else if (issue) begin
                  cmd_valid_d = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cmd_valid_q <= 1'b0;
         wait_rx_q   <= 1'b0;
         idx_q       <= '0;
         bytes_q     <= '0;
         touch_q     <= '0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         cmd_valid_q <= cmd_valid_d;
         wait_rx_q   <= wait_rx_d;
         idx_q       <= idx_d;
         bytes_q     <= bytes_d;
         touch_q     <= touch_d;
         err_count_q <= err_count_d;
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_addr  = I2C_ADDR;
   assign cmd_data  = FT_REG_TD_STATUS;
   assign touch     = touch_q;
   assign err_count = err_count_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ft6206_poller.sv
// Testbench for ft6206_poller with a behavioural FT6206/I2C-master model.
// Expected commands and touch samples are queued when a poll is set up and
// consumed as the DUT issues commands and finishes polls.
module tb_ft6206_poller;
   import ft6206_defines::*;

   localparam int POLL = 200;

   logic       clk;
   logic       rst;
   logic       ena;
   logic       cmd_valid;
   logic       cmd_ready;
   i2c_cmd_t   cmd;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_data;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       nack;
   touch_t     touch;
   logic [7:0] err_count;
   logic       busy;

   int compCount = 0;
   int errCount  = 0;
   int cycleCount = 0;

   logic [15:0] expCmdQ[$];
   logic [24:0] expTouchQ[$];

   logic [39:0] respBytes = '0;
   logic        nackNext = 1'b0;
   logic        rxPending = 1'b0;
   logic        nackPending = 1'b0;
   logic [7:0]  rxByte = '0;
   int          readIdx = 0;
   int          stopCycle = 0;

   ft6206_poller #(
      .CLK_HZ         (20_000),
      .POLL_HZ        (100),
      .I2C_ADDR       (7'h38),
      .DISPLAY_WIDTH  (240),
      .DISPLAY_HEIGHT (320)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd       (cmd),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .nack      (nack),
      .touch     (touch),
      .err_count (err_count),
      .busy      (busy)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to measure poll spacing and latencies.
   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compCount++;
      if (got !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] encodeCmd(input i2c_cmd_t c, input logic [6:0] a, input logic [7:0] d);
      logic [7:0] payload;
      case (c)
         CMD_START_W, CMD_START_R: payload = {1'b0, a};
         CMD_WRITE:                payload = d;
         default:                  payload = 8'h00;
      endcase
      return {5'b0, c, payload};
   endfunction

   // Sets up the slave response for the next poll and queues what the DUT
   // must do with it.
   task automatic applyStimulus(input logic [39:0] resp, input logic doNack,
                                input logic ev, input logic [11:0] ex, input logic [11:0] ey);
      respBytes = resp;
      nackNext  = doNack;
      expCmdQ.push_back(encodeCmd(CMD_START_W, 7'h38, 8'h00));
      if (doNack) begin
         expCmdQ.push_back(encodeCmd(CMD_STOP, 7'h00, 8'h00));
      end else begin
         expCmdQ.push_back(encodeCmd(CMD_WRITE, 7'h00, 8'h02));
         expCmdQ.push_back(encodeCmd(CMD_START_R, 7'h38, 8'h00));
         for (int i = 0; i < 4; i++) expCmdQ.push_back(encodeCmd(CMD_READ_ACK, 7'h00, 8'h00));
         expCmdQ.push_back(encodeCmd(CMD_READ_NACK, 7'h00, 8'h00));
         expCmdQ.push_back(encodeCmd(CMD_STOP, 7'h00, 8'h00));
      end
      expTouchQ.push_back({ev, ex, ey});
   endtask

   task automatic waitForStart(output int startCyc);
      int n;
      n = 0;
      @(negedge clk);
      while (busy !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("poll_start_seen", busy, 1'b1);
      startCyc = cycleCount;
   endtask

   task automatic waitForEnd(output int endCyc);
      int n;
      logic [24:0] expT;
      n = 0;
      while (busy !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("poll_end_seen", busy, 1'b0);
      endCyc = cycleCount;
      if (expTouchQ.size() > 0) begin
         expT = expTouchQ.pop_front();
         checkOutput("touch", touch, expT);
      end else begin
         checkOutput("touch_unexpected", touch, 25'h1FFFFFF);
      end
   endtask

   // I2C master + FT6206 model: logs every accepted command against the
   // expected queue, returns read bytes and optionally NACKs the address.
   initial begin : i2cModel
      logic [15:0] enc;
      forever begin
         @(negedge clk);
         #1;
         rx_valid = 1'b0;
         nack     = 1'b0;
         if (rst) begin
            rxPending   = 1'b0;
            nackPending = 1'b0;
            readIdx     = 0;
         end else begin
            if (rxPending) begin
               rx_valid  = 1'b1;
               rx_data   = rxByte;
               rxPending = 1'b0;
            end
            if (nackPending) begin
               nack        = 1'b1;
               nackPending = 1'b0;
            end
            if (cmd_valid && cmd_ready) begin
               enc = encodeCmd(cmd, cmd_addr, cmd_data);
               if (expCmdQ.size() > 0) checkOutput("cmd_seq", enc, expCmdQ.pop_front());
               else                    checkOutput("cmd_extra", enc, 16'hFFFF);
               case (cmd)
                  CMD_START_W: begin
                     if (nackNext) begin
                        nackPending = 1'b1;
                        nackNext    = 1'b0;
                     end
                  end
                  CMD_START_R: readIdx = 0;
                  CMD_READ_ACK, CMD_READ_NACK: begin
                     rxByte    = (readIdx < 5) ? respBytes[8*(4-readIdx) +: 8] : 8'h00;
                     readIdx   = readIdx + 1;
                     rxPending = 1'b1;
                  end
                  CMD_STOP: stopCycle = cycleCount;
                  default: ;
               endcase
            end
         end
      end
   end

   initial begin
      int rel, s, e, sNack, sStall, sx, busyCount, enaCyc, n;
      rst = 1'b1; ena = 1'b0; cmd_ready = 1'b1;
      rx_valid = 1'b0; rx_data = 8'h00; nack = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_touch", touch, 25'h0);
      checkOutput("rst_cmd_valid", cmd_valid, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_err", err_count, 8'h00);

      // Basic sample; first poll waits for the first terminal count.
      applyStimulus(40'h01_00_64_00_C8, 1'b0, 1'b1, 12'd100, 12'd200);
      rel = cycleCount;
      rst = 1'b0;
      ena = 1'b1;
      waitForStart(s);
      checkOutput("first_poll_delay", s - rel, POLL + 1);
      waitForEnd(e);
      checkOutput("update_latency", e - stopCycle, 2);
      checkOutput("err_after_ok", err_count, 8'h00);

      // Clamping of both axes.
      applyStimulus(40'h01_00_FF_01_90, 1'b0, 1'b1, 12'd239, 12'd319);
      waitForStart(s); waitForEnd(e);

      // No touch, then lift-up: invalid, coordinates held.
      applyStimulus(40'h00_00_00_00_00, 1'b0, 1'b0, 12'd239, 12'd319);
      waitForStart(s); waitForEnd(e);
      applyStimulus(40'h01_40_10_00_20, 1'b0, 1'b0, 12'd239, 12'd319);
      waitForStart(s); waitForEnd(e);

      // Two points, x just past the edge, y in range.
      applyStimulus(40'h02_80_F0_00_7B, 1'b0, 1'b1, 12'd239, 12'd123);
      waitForStart(s); waitForEnd(e);

      // Point count above two is invalid.
      applyStimulus(40'h03_00_05_00_06, 1'b0, 1'b0, 12'd239, 12'd123);
      waitForStart(s); waitForEnd(e);

      // Address NACK: one STOP, error counted, touch unchanged, retry on next tick.
      applyStimulus(40'h01_00_0A_00_14, 1'b1, 1'b0, 12'd239, 12'd123);
      waitForStart(sNack); waitForEnd(e);
      checkOutput("err_after_nack", err_count, 8'h01);
      checkOutput("nack_cmds_drained", expCmdQ.size(), 0);
      applyStimulus(40'h01_00_0A_00_14, 1'b0, 1'b1, 12'd10, 12'd20);
      waitForStart(s);
      checkOutput("retry_period", s - sNack, POLL);
      waitForEnd(e);

      // Polling disabled: nothing starts; the missed tick is serviced on enable.
      ena = 1'b0;
      applyStimulus(40'h02_00_1E_00_28, 1'b0, 1'b1, 12'd30, 12'd40);
      busyCount = 0;
      for (int i = 0; i < 450; i++) begin
         @(negedge clk);
         if (busy) busyCount++;
      end
      checkOutput("ena_low_idle", busyCount, 0);
      enaCyc = cycleCount;
      ena = 1'b1;
      waitForStart(s);
      checkOutput("ena_late_start", s - enaCyc, 1);
      waitForEnd(e);

      // Long stall: fields hold, exactly one catch-up poll, phase preserved.
      applyStimulus(40'h01_00_EF_01_3F, 1'b0, 1'b1, 12'd239, 12'd319);
      applyStimulus(40'h01_00_EF_01_3F, 1'b0, 1'b1, 12'd239, 12'd319);
      waitForStart(sStall);
      cmd_ready = 1'b0;
      for (int i = 0; i < 3 * POLL; i++) begin
         @(negedge clk);
         if (i % 100 == 50) begin
            checkOutput("stall_valid", cmd_valid, 1'b1);
            checkOutput("stall_fields", encodeCmd(cmd, cmd_addr, cmd_data),
                        encodeCmd(CMD_START_W, 7'h38, 8'h00));
         end
      end
      cmd_ready = 1'b1;
      waitForEnd(e);
      waitForStart(sx);
      checkOutput("catchup_gap", sx - e, 1);
      waitForEnd(e);
      applyStimulus(40'h01_C0_05_00_07, 1'b0, 1'b1, 12'd5, 12'd7);
      waitForStart(s);
      checkOutput("post_stall_phase", s - sStall, 4 * POLL);
      waitForEnd(e);

      // Asynchronous reset in the middle of the read burst.
      applyStimulus(40'h01_00_11_00_22, 1'b0, 1'b1, 12'd17, 12'd34);
      waitForStart(s);
      n = 0;
      while (!(readIdx >= 2 && cmd_valid === 1'b1) && n < 300) begin
         @(negedge clk);
         n++;
      end
      checkOutput("reached_read", (readIdx >= 2) && (cmd_valid === 1'b1), 1'b1);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_rst_touch", touch, 25'h0);
      checkOutput("async_rst_cmd_valid", cmd_valid, 1'b0);
      checkOutput("async_rst_busy", busy, 1'b0);
      checkOutput("async_rst_err", err_count, 8'h00);
      expCmdQ.delete();
      expTouchQ.delete();
      nackNext = 1'b0;
      repeat (3) @(negedge clk);
      applyStimulus(40'h01_00_32_00_3C, 1'b0, 1'b1, 12'd50, 12'd60);
      rel = cycleCount;
      rst = 1'b0;
      waitForStart(s);
      checkOutput("rst_first_poll_delay", s - rel, POLL + 1);
      waitForEnd(e);
      checkOutput("final_cmds_drained", expCmdQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
      $finish;
   end

endmodule

// File: doc/ft6206_poller.md
Name: ft6206_poller

Overview:
- Periodically reads the FT6206 capacitive touch controller through the shared byte-level I2C master and publishes a registered touch_t sample.
- Downstream consumers are the etch-a-sketch drawing logic, the same consumer the bench-side touch generator stands in for.
- It is the sequencer for the touch datapath: it issues every I2C command, parses register bytes, clamps coordinates to the display, and handles bus errors.

Parameters:
- CLK_HZ, 12_000_000, system clock frequency.
- POLL_HZ, 100, touch sample rate; POLL_CYCLES = CLK_HZ/POLL_HZ.
- I2C_ADDR, 7'h38, FT6206 7-bit address.
- DISPLAY_WIDTH, 240, x clamp bound.
- DISPLAY_HEIGHT, 320, y clamp bound.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-high.
- ena  in  1  polling enable; when low, no new transactions start.
- cmd_valid  out  1  I2C command strobe.
- cmd_ready  in  1  I2C master can accept a command.
- cmd  out  i2c_cmd_t  command code: START_W, START_R, WRITE, READ_ACK, READ_NACK, STOP.
- cmd_addr  out  7  slave address, meaningful with START_W and START_R.
- cmd_data  out  8  write byte, meaningful with WRITE.
- rx_valid  in  1  one-cycle strobe: read byte available.
- rx_data  in  8  read byte.
- nack  in  1  one-cycle strobe: slave NACKed the address or a written byte.
- touch  out  touch_t  {valid, x[11:0], y[11:0]}, registered.
- err_count  out  8  saturating count of aborted transactions.
- busy  out  1  high outside S_IDLE.

Behaviour:
- Reset (async, any state): state = S_IDLE; poll timer = 0; touch = '0; err_count = 0; cmd_valid = 0.
- Handshake: a command transfers on a cycle where cmd_valid and cmd_ready are both high.
  - cmd, cmd_addr and cmd_data hold stable while cmd_valid is high and cmd_ready is low.
  - cmd_valid drops the cycle after the transfer.
  - READ_ACK and READ_NACK then wait for rx_valid before the FSM advances.
- Poll timer:
  - Counts 0..POLL_CYCLES-1 continuously; the terminal count sets a pending flag.
  - S_IDLE starts a poll when pending && ena, clearing pending.
  - A tick arriving while busy sets pending, so the poll is serviced late, never dropped and never queued twice.
- FSM:
  - S_IDLE -> S_START_W: START_W, I2C_ADDR.
  - S_START_W -> S_WR_REG: WRITE 8'h02 (TD_STATUS).
  - S_WR_REG -> S_START_R: START_R, I2C_ADDR (repeated start).
  - S_START_R -> S_READ: five reads, byte index 0..4; indices 0..3 use READ_ACK, index 4 uses READ_NACK.
  - S_READ -> S_STOP: STOP.
  - S_STOP -> S_UPDATE -> S_IDLE.
- Byte capture: b0 = TD_STATUS, b1 = P1_XH, b2 = P1_XL, b3 = P1_YH, b4 = P1_YL.
- S_UPDATE (single cycle):
  - n = b0[3:0]; raw_x = {b1[3:0], b2}; raw_y = {b3[3:0], b4}.
  - touch.valid = (n == 1 || n == 2) && b1[7:6] != 2'b01. Event 01 is lift-up. n > 2 is invalid and gives valid = 0.
  - When valid: touch.x = min(raw_x, DISPLAY_WIDTH-1); touch.y = min(raw_y, DISPLAY_HEIGHT-1).
  - When not valid: x and y hold their previous values.
  - touch changes only in S_UPDATE, or on reset.
- Error handling:
  - nack in any state after START_W is accepted -> S_ABORT.
  - S_ABORT issues STOP, increments err_count (saturating at 255), leaves touch unchanged, returns to S_IDLE, and retries on the next tick.
- ena deasserted mid-transaction: the current transaction completes; no new one starts.
- Simultaneous rx_valid and nack: nack wins.

Decomposition:
- ft6206_defines package:
  - i2c_cmd_t enum.
  - touch_t packed struct.
  - FT6206 register constants (TD_STATUS = 8'h02), event code EVT_LIFT = 2'b01, default address 7'h38.
  - poller state enum.
- Sub-module poll_timer: counter plus pending-flag logic. Parameter CYCLES; ports clk, rst, clear, pending.

Test Plan:
- I2C model ACKs everything and returns 01,00,64,00,C8 (n=1, x=100, y=200) -> command order is START_W(38), WRITE(02), START_R(38), 4×READ_ACK, READ_NACK, STOP; touch = {1,100,200} the cycle after STOP is accepted; err_count = 0.
- Returns 01,00,FF,01,90 (x=255, y=400) -> touch.x = 239, touch.y = 319, valid = 1.
- Returns 00,... then 01,40,10,00,20 (lift-up event) -> valid = 0 both polls; x and y keep the prior sample.
- NACK on START_W -> one STOP issued, err_count = 1, touch unchanged, next poll starts exactly one POLL_CYCLES period later.
- cmd_ready held low 3×POLL_CYCLES during one poll -> exactly one extra poll follows immediately; cmd fields stable while stalled.
- rst asserted mid-S_READ (no clock edge needed) -> touch = 0, cmd_valid = 0, busy = 0 immediately; after release, the first poll starts at the first timer terminal count.
